// File: rtl/tuning_word_estimator.sv
// Recovers a DDS frequency tuning word by counting rising edges of a 1-bit
// periodic signal over a gate of DEPTH<<AVG_LOG2 clocks.
module tuning_word_estimator #(
    parameter int DEPTH    = 1024,
    parameter int AVG_LOG2 = 0
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_start,
    input  logic                     i_stop,
    input  logic                     i_continuous,
    input  logic                     i_sig,
    output logic [$clog2(DEPTH)-1:0] o_tuning_word,
    output logic                     o_valid,
    output logic                     o_nyquist,
    output logic                     o_busy
);
    localparam int LW = $clog2(DEPTH);
    localparam int CW = LW + AVG_LOG2 + 1;
    localparam logic [CW-1:0] LAST = CW'((DEPTH << AVG_LOG2) - 1);
    localparam logic [LW-1:0] HALF = LW'(DEPTH / 2);

    typedef enum logic {IDLE, GATE} state_t;

    state_t          r_state, w_state_nxt;
    logic            r_prev, w_prev_nxt;
    logic [CW-1:0]   r_timer, w_timer_nxt;
    logic [CW-1:0]   r_edges, w_edges_nxt;
    logic [LW-1:0]   r_word, w_word_nxt;
    logic            r_valid, w_valid_nxt;
    logic            r_nyq, w_nyq_nxt;

    logic            w_rise;
    logic            w_last;
    logic [CW-1:0]   w_edges_tot;
    logic [LW-1:0]   w_result;

    // Averaging divides the total edge count by 2^AVG_LOG2, truncating.
    function automatic logic [LW-1:0] f_scale(input logic [CW-1:0] edges);
        return LW'(edges >> AVG_LOG2);
    endfunction

    assign w_rise      = i_sig & ~r_prev;
    assign w_last      = (r_timer == LAST);
    assign w_edges_tot = r_edges + CW'(w_rise);
    assign w_result    = f_scale(w_edges_tot);

    always_comb begin
        w_state_nxt = r_state;
        w_prev_nxt  = r_prev;
        w_timer_nxt = r_timer;
        w_edges_nxt = r_edges;
        w_word_nxt  = r_word;
        w_valid_nxt = 1'b0;
        w_nyq_nxt   = 1'b0;
        if (i_stop) begin
            w_state_nxt = IDLE;
            w_timer_nxt = '0;
            w_edges_nxt = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        // Reference sample only; the first comparison happens next cycle.
                        w_prev_nxt  = i_sig;
                        w_timer_nxt = '0;
                        w_edges_nxt = '0;
                        w_state_nxt = GATE;
                    end
                end
                GATE: begin
                    w_prev_nxt = i_sig;
                    if (w_last) begin
                        w_valid_nxt = 1'b1;
                        w_word_nxt  = w_result;
                        w_nyq_nxt   = (w_result == HALF);
                        w_timer_nxt = '0;
                        w_edges_nxt = '0;
                        if (!i_continuous) begin
                            w_state_nxt = IDLE;
                        end
                    end else begin
                        w_timer_nxt = r_timer + 1'b1;
                        w_edges_nxt = w_edges_tot;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_prev  <= 1'b0;
            r_timer <= '0;
            r_edges <= '0;
            r_word  <= '0;
            r_valid <= 1'b0;
            r_nyq   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_prev  <= w_prev_nxt;
            r_timer <= w_timer_nxt;
            r_edges <= w_edges_nxt;
            r_word  <= w_word_nxt;
            r_valid <= w_valid_nxt;
            r_nyq   <= w_nyq_nxt;
        end
    end

    assign o_tuning_word = r_word;
    assign o_valid       = r_valid;
    assign o_nyquist     = r_nyq;
    assign o_busy        = (r_state == GATE);
endmodule

// File: tb/tb_tuning_word_estimator.sv
// Bench for tuning_word_estimator: DDS-driven and random signals measured by
// three instances (DEPTH=1024/AVG=0, DEPTH=1024/AVG=2, DEPTH=16/AVG=0).
module tb_tuning_word_estimator;
    logic       clk = 1'b0;
    logic       rst, stop, cont, sig;
    logic [2:0] st;

    logic       v0, n0, b0, v2, n2, b2, v16, n16, b16;
    logic [9:0] w0, w2;
    logic [3:0] w16;

    int n_chk = 0;
    int n_bad = 0;

    // Stimulus generator state: 0 = DDS MSB, 1 = hold, 2 = toggle, 3 = random bits
    int mode, phase, step, dds_depth, model_edges;

    always #5 clk = ~clk;

    tuning_word_estimator #(.DEPTH(1024), .AVG_LOG2(0)) u0 (
        .i_clk(clk), .i_rst(rst), .i_start(st[0]), .i_stop(stop), .i_continuous(cont),
        .i_sig(sig), .o_tuning_word(w0), .o_valid(v0), .o_nyquist(n0), .o_busy(b0));
    tuning_word_estimator #(.DEPTH(1024), .AVG_LOG2(2)) u2 (
        .i_clk(clk), .i_rst(rst), .i_start(st[1]), .i_stop(stop), .i_continuous(cont),
        .i_sig(sig), .o_tuning_word(w2), .o_valid(v2), .o_nyquist(n2), .o_busy(b2));
    tuning_word_estimator #(.DEPTH(16), .AVG_LOG2(0)) u16 (
        .i_clk(clk), .i_rst(rst), .i_start(st[2]), .i_stop(stop), .i_continuous(cont),
        .i_sig(sig), .o_tuning_word(w16), .o_valid(v16), .o_nyquist(n16), .o_busy(b16));

    task automatic check_eq(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int get_v(input int k);
        case (k)
            0: return int'(v0);
            1: return int'(v2);
            default: return int'(v16);
        endcase
    endfunction
    function automatic int get_w(input int k);
        case (k)
            0: return int'(w0);
            1: return int'(w2);
            default: return int'(w16);
        endcase
    endfunction
    function automatic int get_n(input int k);
        case (k)
            0: return int'(n0);
            1: return int'(n2);
            default: return int'(n16);
        endcase
    endfunction
    function automatic int get_b(input int k);
        case (k)
            0: return int'(b0);
            1: return int'(b2);
            default: return int'(b16);
        endcase
    endfunction

    task automatic clk1();
        @(posedge clk);
        #1;
    endtask

    // Produce the i_sig value for the next clock edge and count its rising edges.
    task automatic adv();
        logic nsig;
        case (mode)
            0: begin
                phase = (phase + step) % dds_depth;
                nsig  = (phase >= dds_depth / 2);
            end
            1: nsig = sig;
            2: nsig = ~sig;
            default: nsig = 1'($urandom % 2);
        endcase
        if (nsig && !sig) model_edges++;
        sig = nsig;
    endtask

    task automatic set_dds(input int m, input int depth, input int ph);
        mode = 0; step = m; dds_depth = depth; phase = ph;
        sig = (phase >= depth / 2);
    endtask

    // One single-shot measurement; exp_word < 0 means use the edge-count model.
    task automatic measure(input int k, input int W, input int avg, input int depth,
                           input int exp_word, input string tag);
        int early, ex;
        early = 0;
        st[k] = 1'b1;
        clk1();
        st[k] = 1'b0;
        model_edges = 0;
        adv();
        for (int n = 1; n <= W; n++) begin
            clk1();
            if (n < W) begin
                if (get_v(k) != 0) early++;
                adv();
            end
        end
        ex = (exp_word < 0) ? (model_edges >> avg) : exp_word;
        check_eq({tag, "_early_valid"}, early, 0);
        check_eq({tag, "_valid"}, get_v(k), 1);
        check_eq({tag, "_word"}, get_w(k), ex);
        check_eq({tag, "_nyq"}, get_n(k), (ex == depth / 2) ? 1 : 0);
        clk1();
        check_eq({tag, "_valid_drop"}, get_v(k), 0);
        check_eq({tag, "_busy_after"}, get_b(k), 0);
    endtask

    initial begin
        int nv, cnt;
        rst = 1'b1; stop = 1'b0; cont = 1'b0; st = '0; sig = 1'b0;
        mode = 1; phase = 0; step = 0; dds_depth = 1024; model_edges = 0;
        repeat (3) clk1();
        check_eq("rst_valid", int'(v0), 0);
        check_eq("rst_word", int'(w0), 0);
        check_eq("rst_busy", int'(b0), 0);
        check_eq("rst_nyq", int'(n0), 0);
        rst = 1'b0;
        clk1();

        set_dds(37, 1024, 0);
        measure(0, 1024, 0, 1024, 37, "m37");
        for (int i = 0; i < 3; i++) begin
            int m;
            m = int'($urandom_range(1, 511));
            set_dds(m, 1024, int'($urandom_range(0, 1023)));
            measure(0, 1024, 0, 1024, m, "rand_m");
        end

        set_dds(5, 1024, int'($urandom_range(0, 1023)));
        measure(1, 4096, 2, 1024, 5, "avg_m5");
        mode = 1; sig = 1'b1;
        measure(1, 4096, 2, 1024, 0, "avg_const1");
        mode = 3;
        measure(1, 4096, 2, 1024, -1, "avg_rand_bits");

        // Continuous: step changes exactly at the window boundary.
        cont = 1'b1;
        set_dds(100, 1024, int'($urandom_range(0, 1023)));
        st[0] = 1'b1;
        clk1();
        st[0] = 1'b0;
        adv();
        nv = 0;
        for (int n = 1; n <= 2048; n++) begin
            clk1();
            if (v0) begin
                nv++;
                if (nv == 1) begin
                    check_eq("cont_t1", n, 1024);
                    check_eq("cont_w1", int'(w0), 100);
                end else if (nv == 2) begin
                    check_eq("cont_t2", n, 2048);
                    check_eq("cont_w2", int'(w0), 200);
                end
            end
            if (n == 1024) step = 200;
            if (n == 1025) cont = 1'b0;
            adv();
        end
        clk1();
        check_eq("cont_nvalid", nv, 2);
        check_eq("cont_busy_after", int'(b0), 0);

        // Abandon mid-gate.
        set_dds(60, 1024, 0);
        st[0] = 1'b1;
        clk1();
        st[0] = 1'b0;
        adv();
        for (int n = 1; n < 500; n++) begin
            clk1();
            adv();
        end
        stop = 1'b1;
        clk1();
        stop = 1'b0;
        check_eq("stop_busy", int'(b0), 0);
        cnt = 0;
        for (int n = 0; n < 1100; n++) begin
            clk1();
            if (v0) cnt++;
            adv();
        end
        check_eq("stop_no_valid", cnt, 0);
        check_eq("stop_word_kept", int'(w0), 200);
        set_dds(9, 1024, int'($urandom_range(0, 1023)));
        measure(0, 1024, 0, 1024, 9, "restart_m9");

        // Reset in the middle of a gate.
        set_dds(50, 1024, 0);
        st[0] = 1'b1;
        clk1();
        st[0] = 1'b0;
        for (int n = 0; n < 300; n++) begin
            adv();
            clk1();
        end
        rst = 1'b1;
        clk1();
        rst = 1'b0;
        check_eq("midrst_valid", int'(v0), 0);
        check_eq("midrst_word", int'(w0), 0);
        check_eq("midrst_busy", int'(b0), 0);
        check_eq("midrst_nyq", int'(n0), 0);

        // Start and stop together: stop wins.
        st[0] = 1'b1; stop = 1'b1;
        clk1();
        st[0] = 1'b0; stop = 1'b0;
        check_eq("startstop_busy", int'(b0), 0);
        cnt = 0;
        for (int n = 0; n < 1100; n++) begin
            clk1();
            if (v0 || b0) cnt++;
        end
        check_eq("startstop_idle", cnt, 0);

        mode = 2;
        measure(0, 1024, 0, 1024, 512, "toggle");
        mode = 3;
        measure(0, 1024, 0, 1024, -1, "rand_bits");
        set_dds(3, 16, int'($urandom_range(0, 15)));
        measure(2, 16, 0, 16, 3, "d16_m3");
        mode = 2;
        measure(2, 16, 0, 16, 8, "d16_toggle");
        for (int i = 0; i < 4; i++) begin
            int m;
            m = int'($urandom_range(1, 7));
            set_dds(m, 16, int'($urandom_range(0, 15)));
            measure(2, 16, 0, 16, m, "d16_rand_m");
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
